// File: rtl/qbits_param_sequencer_if.sv
// Request/result bundle for qbits_param_sequencer.
//  Request side : in_valid/in_ready handshake carrying QP, bit depth and log2 TU size.
//  Result side  : out_valid/out_ready handshake carrying per, rem, shift, iQBits,
//                 quant scale and the QP range error flag.
//  busy         : sequencer status, high whenever a TU is in flight.
// The slave modport is the sequencer's view. The master modport is the view of
// whatever drives requests and consumes results.
interface qbits_param_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_qp;
    logic [3:0]  in_bit_depth;
    logic [2:0]  in_log2_size;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_per;
    logic [2:0]  out_rem;
    logic [5:0]  out_shift;
    logic [5:0]  out_qbits;
    logic [15:0] out_scale;
    logic        out_err;
    logic        busy;

    modport slave (
        input  in_valid, in_qp, in_bit_depth, in_log2_size, out_ready,
        output in_ready, out_valid, out_per, out_rem, out_shift, out_qbits,
               out_scale, out_err, busy
    );

    modport master (
        output in_valid, in_qp, in_bit_depth, in_log2_size, out_ready,
        input  in_ready, out_valid, out_per, out_rem, out_shift, out_qbits,
               out_scale, out_err, busy
    );
endinterface

// File: rtl/qbits_param_sequencer.sv
// Per-TU quantization parameter sequencer for the RDOQ datapath.
// It accepts one TU request and splits QP into per = QP/6 and rem = QP%6. The
// split uses one subtract-6 step per clock instead of a divider. It then derives
// the transform shift, iQBits and the quant scale. The result is held on the
// output handshake until downstream takes it. Only one TU is in flight at a time.
// Ports:
//  clk : clock, all logic on the rising edge
//  rst : synchronous reset, active-high; discards any in-flight TU
//  bus : qbits_param_sequencer_if.slave (request in, result out, busy)
module qbits_param_sequencer #(
    parameter int MAX_TR_DYN_RANGE = 15,
    parameter int QP_MAX           = 59,
    parameter int QBITS_BASE       = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    qbits_param_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } stateT;

    stateT       state;
    logic [5:0]  remAcc;
    logic [3:0]  perCnt;
    logic [3:0]  bitDepth;
    logic [2:0]  log2Size;
    logic        errFlag;
    logic        inReady;
    logic        outValid;
    logic [3:0]  outPer;
    logic [2:0]  outRem;
    logic [5:0]  outShift;
    logic [5:0]  outQbits;
    logic [15:0] outScale;
    logic        outErr;

    // Shift arithmetic is 7-bit. The worst legal-width case is 15 - 15 - 7 = -7,
    // and that still fits, so bit 6 acts as the sign.
    logic [6:0]  shRaw;
    logic [5:0]  shClamp;
    logic [5:0]  qbitsCalc;
    logic [15:0] scaleCalc;

    always_comb begin
        shRaw     = 7'(MAX_TR_DYN_RANGE) - {3'b000, bitDepth} - {4'b0000, log2Size};
        shClamp   = shRaw[6] ? 6'd0 : shRaw[5:0];
        // per <= 9 and shift <= 15 keep this below 64.
        qbitsCalc = 6'(QBITS_BASE) + {2'b00, perCnt} + shClamp;
        scaleCalc = 16'd0;
        case (remAcc[2:0])
            3'd0:    scaleCalc = 16'd26214;
            3'd1:    scaleCalc = 16'd23302;
            3'd2:    scaleCalc = 16'd20560;
            3'd3:    scaleCalc = 16'd18396;
            3'd4:    scaleCalc = 16'd16384;
            3'd5:    scaleCalc = 16'd14564;
            default: scaleCalc = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            remAcc   <= '0;
            perCnt   <= '0;
            bitDepth <= '0;
            log2Size <= '0;
            errFlag  <= 1'b0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            outPer   <= '0;
            outRem   <= '0;
            outShift <= '0;
            outQbits <= '0;
            outScale <= '0;
            outErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && inReady) begin
                        inReady  <= 1'b0;
                        bitDepth <= bus.in_bit_depth;
                        log2Size <= bus.in_log2_size;
                        perCnt   <= '0;
                        if (bus.in_qp <= 6'(QP_MAX)) begin
                            remAcc  <= bus.in_qp;
                            errFlag <= 1'b0;
                            state   <= DIV;
                        end else begin
                            // The error result is loaded here. It passes through
                            // CALC untouched, so it becomes visible one edge after accept.
                            remAcc   <= '0;
                            errFlag  <= 1'b1;
                            outErr   <= 1'b1;
                            outPer   <= '0;
                            outRem   <= '0;
                            outShift <= '0;
                            outQbits <= '0;
                            outScale <= '0;
                            state    <= CALC;
                        end
                    end
                end
                DIV: begin
                    if (remAcc >= 6'd6) begin
                        remAcc <= remAcc - 6'd6;
                        perCnt <= perCnt + 4'd1;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (!errFlag) begin
                        outPer   <= perCnt;
                        outRem   <= remAcc[2:0];
                        outShift <= shClamp;
                        outQbits <= qbitsCalc;
                        outScale <= scaleCalc;
                        outErr   <= 1'b0;
                    end
                    outValid <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_per   = outPer;
    assign bus.out_rem   = outRem;
    assign bus.out_shift = outShift;
    assign bus.out_qbits = outQbits;
    assign bus.out_scale = outScale;
    assign bus.out_err   = outErr;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_qbits_param_sequencer.sv
module tb_qbits_param_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    qbits_param_sequencer_if bus ();

    qbits_param_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  qp;
        logic [3:0]  bd;
        logic [2:0]  lg;
        logic [3:0]  per;
        logic [2:0]  rem;
        logic [5:0]  shift;
        logic [5:0]  qbits;
        logic [15:0] scale;
        int          lat;
    } vecT;

    // Drive one request and return the number of edges from accept (edge 0)
    // until out_valid is seen high. Both waits are bounded.
    task automatic sendReq(input logic [5:0] qp, input logic [3:0] bd,
                           input logic [2:0] lg, output int lat);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_qp = qp; bus.in_bit_depth = bd; bus.in_log2_size = lg;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("req qp=%0d bd=%0d lg=%0d -> lat=%0d per=%0d rem=%0d shift=%0d qbits=%0d scale=%0d err=%b",
                 qp, bd, lg, lat, bus.out_per, bus.out_rem, bus.out_shift,
                 bus.out_qbits, bus.out_scale, bus.out_err);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if ({bus.out_per, bus.out_rem, bus.out_shift, bus.out_qbits, bus.out_scale, bus.out_err} !== 36'd0) begin
            errors++;
            $display("FAIL reset_fields: got per=%0d rem=%0d shift=%0d qbits=%0d scale=%0d err=%b expected all 0",
                     bus.out_per, bus.out_rem, bus.out_shift, bus.out_qbits, bus.out_scale, bus.out_err);
        end
        $display("test_reset done");
    endtask

    task automatic test_normal();
        vecT vecs[7];
        int  lat;
        vecs[0] = '{6'd0,  4'd8,  3'd2, 4'd0, 3'd0, 6'd5, 6'd19, 16'd26214, 2};
        vecs[1] = '{6'd37, 4'd8,  3'd4, 4'd6, 3'd1, 6'd3, 6'd23, 16'd23302, 8};
        vecs[2] = '{6'd59, 4'd10, 3'd5, 4'd9, 3'd5, 6'd0, 6'd23, 16'd14564, 11};
        vecs[3] = '{6'd30, 4'd12, 3'd5, 4'd5, 3'd0, 6'd0, 6'd19, 16'd26214, 7};
        vecs[4] = '{6'd23, 4'd9,  3'd3, 4'd3, 3'd5, 6'd3, 6'd20, 16'd14564, 5};
        vecs[5] = '{6'd16, 4'd8,  3'd3, 4'd2, 3'd4, 6'd4, 6'd20, 16'd16384, 4};
        vecs[6] = '{6'd9,  4'd8,  3'd2, 4'd1, 3'd3, 6'd5, 6'd20, 16'd18396, 3};
        for (int i = 0; i < 7; i++) begin
            sendReq(vecs[i].qp, vecs[i].bd, vecs[i].lg, lat);
            checks++; if (lat != vecs[i].lat) begin errors++; $display("FAIL normal%0d_latency: got %0d expected %0d", i, lat, vecs[i].lat); end
            checks++; if (bus.out_per !== vecs[i].per) begin errors++; $display("FAIL normal%0d_per: got %0d expected %0d", i, bus.out_per, vecs[i].per); end
            checks++; if (bus.out_rem !== vecs[i].rem) begin errors++; $display("FAIL normal%0d_rem: got %0d expected %0d", i, bus.out_rem, vecs[i].rem); end
            checks++; if (bus.out_shift !== vecs[i].shift) begin errors++; $display("FAIL normal%0d_shift: got %0d expected %0d", i, bus.out_shift, vecs[i].shift); end
            checks++; if (bus.out_qbits !== vecs[i].qbits) begin errors++; $display("FAIL normal%0d_qbits: got %0d expected %0d", i, bus.out_qbits, vecs[i].qbits); end
            checks++; if (bus.out_scale !== vecs[i].scale) begin errors++; $display("FAIL normal%0d_scale: got %0d expected %0d", i, bus.out_scale, vecs[i].scale); end
            checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL normal%0d_err: got %b expected 0", i, bus.out_err); end
            checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL normal%0d_status: in_ready=%b busy=%b expected 0/1", i, bus.in_ready, bus.busy); end
            consume();
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL normal%0d_release: out_valid=%b in_ready=%b busy=%b expected 0/1/0", i, bus.out_valid, bus.in_ready, bus.busy);
            end
        end
    endtask

    task automatic test_error();
        int lat;
        sendReq(6'd60, 4'd8, 3'd2, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL err_latency: got %0d expected 1", lat); end
        checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", bus.out_err); end
        checks++;
        if ({bus.out_per, bus.out_rem, bus.out_shift, bus.out_qbits, bus.out_scale} !== 35'd0) begin
            errors++;
            $display("FAIL err_fields: got per=%0d rem=%0d shift=%0d qbits=%0d scale=%0d expected all 0",
                     bus.out_per, bus.out_rem, bus.out_shift, bus.out_qbits, bus.out_scale);
        end
        consume();
        sendReq(6'd6, 4'd8, 3'd2, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL after_err_latency: got %0d expected 3", lat); end
        checks++;
        if (bus.out_per !== 4'd1 || bus.out_rem !== 3'd0 || bus.out_err !== 1'b0 ||
            bus.out_qbits !== 6'd20 || bus.out_scale !== 16'd26214) begin
            errors++;
            $display("FAIL after_err_result: got per=%0d rem=%0d err=%b qbits=%0d scale=%0d expected 1/0/0/20/26214",
                     bus.out_per, bus.out_rem, bus.out_err, bus.out_qbits, bus.out_scale);
        end
        consume();
        sendReq(6'd63, 4'd8, 3'd2, lat);
        checks++; if (lat != 1 || bus.out_err !== 1'b1 || bus.out_qbits !== 6'd0) begin
            errors++; $display("FAIL err63: lat=%0d err=%b qbits=%0d expected 1/1/0", lat, bus.out_err, bus.out_qbits);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        sendReq(6'd13, 4'd10, 3'd3, lat);
        checks++; if (lat != 4 || bus.out_qbits !== 6'd18 || bus.out_scale !== 16'd23302) begin
            errors++; $display("FAIL bp_result: lat=%0d qbits=%0d scale=%0d expected 4/18/23302", lat, bus.out_qbits, bus.out_scale);
        end
        // Offer a competing request while the result is stalled; it must not be taken.
        bus.in_qp = 6'd0; bus.in_bit_depth = 4'd8; bus.in_log2_size = 3'd2; bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            $display("stall cycle %0d: out_valid=%b in_ready=%b per=%0d rem=%0d qbits=%0d", c, bus.out_valid, bus.in_ready, bus.out_per, bus.out_rem, bus.out_qbits);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_per !== 4'd2 ||
                bus.out_rem !== 3'd1 || bus.out_shift !== 6'd2 || bus.out_qbits !== 6'd18) begin
                errors++;
                $display("FAIL bp_stall%0d: out_valid=%b in_ready=%b per=%0d rem=%0d shift=%0d qbits=%0d expected 1/0/2/1/2/18",
                         c, bus.out_valid, bus.in_ready, bus.out_per, bus.out_rem, bus.out_shift, bus.out_qbits);
            end
        end
        bus.in_valid = 1'b0;
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.out_ready = 1'b1;
        sendReq(6'd5, 4'd8, 3'd2, lat);
        checks++; if (lat != 2 || bus.out_rem !== 3'd5 || bus.out_scale !== 16'd14564 || bus.out_qbits !== 6'd19) begin
            errors++; $display("FAIL b2b_first: lat=%0d rem=%0d scale=%0d qbits=%0d expected 2/5/14564/19", lat, bus.out_rem, bus.out_scale, bus.out_qbits);
        end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_ready: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
        sendReq(6'd12, 4'd8, 3'd2, lat);
        checks++; if (lat != 4 || bus.out_per !== 4'd2 || bus.out_rem !== 3'd0 || bus.out_qbits !== 6'd21) begin
            errors++; $display("FAIL b2b_second: lat=%0d per=%0d rem=%0d qbits=%0d expected 4/2/0/21", lat, bus.out_per, bus.out_rem, bus.out_qbits);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat;
        bus.in_qp = 6'd59; bus.in_bit_depth = 4'd8; bus.in_log2_size = 3'd2; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL middiv_busy: busy=%b in_ready=%b expected 1/0", bus.busy, bus.in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL middiv_reset: busy=%b in_ready=%b out_valid=%b expected 0/1/0", bus.busy, bus.in_ready, bus.out_valid);
        end
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL middiv_no_output: out_valid high %0d cycles expected 0", seen); end
        sendReq(6'd0, 4'd8, 3'd2, lat);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_qbits !== 6'd0) begin
            errors++; $display("FAIL out_reset: out_valid=%b in_ready=%b qbits=%0d expected 0/1/0", bus.out_valid, bus.in_ready, bus.out_qbits);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.in_valid = 1'b0;
        bus.in_qp = '0;
        bus.in_bit_depth = '0;
        bus.in_log2_size = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        test_reset();
        test_normal();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
